// File: rtl/ftf_decoder_pipe_pkg.sv
// ftf_decoder_pipe_pkg: Fibonacci weights, data-width sizing and greedy FTF encoding
// shared by the FTF decoder pipeline and the FTF encoders.
package ftf_decoder_pipe_pkg;

    localparam int FNS_MAX = 18;

    function automatic int unsigned fns(input int k);
        int unsigned a, b, t;
        a = 0;
        b = 1;
        for (int i = 0; i < FNS_MAX; i++)
            if (i < k) begin
                t = a + b;
                a = b;
                b = t;
            end
        return a;
    endfunction

    function automatic int dw_min(input int cw);
        return $clog2(fns(cw + 2));
    endfunction

    function automatic logic [FNS_MAX-1:0] greedy_encode(input int unsigned value, input int cw);
        logic [FNS_MAX-1:0] code;
        int unsigned rem;
        code = '0;
        rem = value;
        for (int i = FNS_MAX - 1; i >= 0; i--)
            if (i < cw && rem >= fns(i + 1)) begin
                code[i] = 1'b1;
                rem -= fns(i + 1);
            end
        return code;
    endfunction

endpackage

// File: rtl/ftf_fns_partial_sum.sv
// ftf_fns_partial_sum: Fibonacci-weighted sum of a codeword slice whose bit 0
// sits at codeword index START.
module ftf_fns_partial_sum
    import ftf_decoder_pipe_pkg::*;
#(
    parameter int W     = 1,
    parameter int START = 0,
    parameter int OW    = 3
) (
    input  logic [W-1:0]  bits,
    output logic [OW-1:0] sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < W; i++)
            sum = sum + (bits[i] ? OW'(fns(START + i + 1)) : OW'(0));
    end

endmodule

// File: rtl/ftf_decoder_pipe.sv
// ftf_decoder_pipe: two-stage FTF codeword to binary decoder with valid/ready backpressure.
// Define FTF_DEC_CHECK_EN to add canonical-form checking (out_err) and a saturating err_cnt.
module ftf_decoder_pipe
    import ftf_decoder_pipe_pkg::*;
#(
    parameter int CW   = 3,
    parameter int DW   = 3,
    parameter int ERRW = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [CW-1:0]   in_code,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_err,
    output logic [ERRW-1:0] err_cnt
);

    localparam int LW = CW / 2;

    logic          s1_valid, s1_adv, s2_adv;
    logic [DW-1:0] lo, hi, s1_lo, s1_hi, s1_sum;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = s2_adv || !s1_valid;
    assign in_ready = s1_adv;
    assign s1_sum   = s1_lo + s1_hi;

    ftf_fns_partial_sum #(.W(LW), .START(0), .OW(DW)) u_lo (
        .bits(in_code[LW-1:0]),
        .sum (lo)
    );

    ftf_fns_partial_sum #(.W(CW - LW), .START(LW), .OW(DW)) u_hi (
        .bits(in_code[CW-1:LW]),
        .sum (hi)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_lo <= lo;
                    s1_hi <= hi;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) out_data <= s1_sum;
            end
        end
    end

`ifdef FTF_DEC_CHECK_EN
    logic [CW-1:0]   s1_code, enc;
    logic            err_r;
    logic [ERRW-1:0] cnt;

    // a canonical codeword is exactly what greedy re-encoding of its value yields
    assign enc     = CW'(greedy_encode(32'(s1_sum), CW));
    assign out_err = err_r;
    assign err_cnt = cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            err_r <= 1'b0;
            cnt   <= '0;
        end else begin
            if (s1_adv && in_valid) s1_code <= in_code;
            if (s2_adv && s1_valid) err_r <= enc != s1_code;
            if (out_valid && out_ready && err_r && cnt != '1) cnt <= cnt + 1'b1;
        end
    end
`else
    assign out_err = 1'b0;
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ftf_decoder_pipe.sv
// tb_ftf_decoder_pipe: table-driven, scoreboard-checked bench for ftf_decoder_pipe (CW=3, DW=3);
// a second instance with ERRW=2 shares the stimulus to observe counter saturation.
module tb_ftf_decoder_pipe;

    localparam int CW = 3;
    localparam int DW = 3;
`ifdef FTF_DEC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clock = 1'b0, reset = 1'b1;
    logic [CW-1:0] in_code = '0;
    logic          in_valid = 1'b0, out_ready = 1'b1;
    logic          in_ready, out_valid, out_err;
    logic [DW-1:0] out_data;
    logic [7:0]    err_cnt;
    logic          in_ready2, out_valid2, out_err2;
    logic [DW-1:0] out_data2;
    logic [1:0]    err_cnt2;

    ftf_decoder_pipe #(.CW(CW), .DW(DW), .ERRW(8)) dut (
        .clock(clock), .reset(reset), .in_code(in_code), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_err(out_err), .err_cnt(err_cnt)
    );

    ftf_decoder_pipe #(.CW(CW), .DW(DW), .ERRW(2)) dut2 (
        .clock(clock), .reset(reset), .in_code(in_code), .in_valid(in_valid),
        .in_ready(in_ready2), .out_data(out_data2), .out_valid(out_valid2),
        .out_ready(out_ready), .out_err(out_err2), .err_cnt(err_cnt2)
    );

    always #5 clock = ~clock;

    typedef struct { logic [CW-1:0] code; int data; bit err; } vec_t;
    typedef struct { int data; bit err; int cyc; bit lat; } exp_t;

    vec_t tab[8];
    exp_t q[$];
    int   total = 0, bad = 0, cyc = 0, exp_cnt = 0;
    bit   chk_lat = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one clock: settle inputs, score the handshakes that will fire on the coming edge
    task automatic step();
        exp_t e;
        #1;
        if (!reset) begin
            chk("err_cnt", int'(err_cnt), CHK ? (exp_cnt > 255 ? 255 : exp_cnt) : 0);
            chk("err_cnt_sat2", int'(err_cnt2), CHK ? (exp_cnt > 3 ? 3 : exp_cnt) : 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_out", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("out_data", int'(out_data), e.data);
                    chk("out_err", int'(out_err), int'(e.err));
                    if (e.lat) chk("latency", cyc - e.cyc, 2);
                    if (e.err) exp_cnt++;
                end
            end
            if (in_valid && in_ready)
                q.push_back('{tab[in_code].data, CHK && tab[in_code].err, cyc, chk_lat});
        end
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        tab[0] = '{3'b000, 0, 1'b0};
        tab[1] = '{3'b001, 1, 1'b1};
        tab[2] = '{3'b010, 1, 1'b0};
        tab[3] = '{3'b011, 2, 1'b1};
        tab[4] = '{3'b100, 2, 1'b0};
        tab[5] = '{3'b101, 3, 1'b1};
        tab[6] = '{3'b110, 3, 1'b0};
        tab[7] = '{3'b111, 4, 1'b0};

        @(negedge clock);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);

        // single all-ones word, two-cycle latency
        chk_lat  = 1'b1;
        in_code  = 3'b111;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("not_early", int'(out_valid), 0);
        step();
        chk("max_valid", int'(out_valid), 1);
        chk("max_data", int'(out_data), 4);
        step();
        step();

        // back-to-back stream, no bubbles
        foreach (tab[i]) begin
            if (i == 0 || i == 1 || i == 2 || i == 4 || i == 6) begin
                in_code  = tab[i].code;
                in_valid = 1'b1;
                #1;
                chk("b2b_in_ready", int'(in_ready), 1);
                step();
            end
        end
        in_valid = 1'b0;
        step();
        step();
        step();

        // fill and stall
        chk_lat   = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 3'b010;
        step();
        in_code = 3'b110;
        step();
        in_code = 3'b111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_out_data", int'(out_data), 1);
            step();
        end
        drain();

        // reset while full and stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 3'b101;
        step();
        in_code = 3'b011;
        step();
        in_valid = 1'b0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        q.delete();
        exp_cnt = 0;
        #1;
        chk("rst2_out_valid", int'(out_valid), 0);
        chk("rst2_in_ready", int'(in_ready), 1);
        chk("rst2_err_cnt", int'(err_cnt), 0);
        chk("rst2_out_data", int'(out_data), 0);
        step();
        chk("rst2_flushed", int'(out_valid), 0);

        // non-canonical pair then a canonical word
        chk_lat   = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = 3'b101;
        step();
        in_code = 3'b011;
        step();
        in_code = 3'b110;
        step();
        drain();
        chk("err_cnt_two", int'(err_cnt), CHK ? 2 : 0);

        // full table sweep
        foreach (tab[i]) begin
            in_code  = tab[i].code;
            in_valid = 1'b1;
            step();
        end
        drain();

        // random traffic with random backpressure
        chk_lat = 1'b0;
        for (int i = 0; i < 80; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_code   = CW'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ftf_decoder_pipe.md
Name: ftf_decoder_pipe

Overview:
- Receive-side counterpart of the FTF (Fibonacci numeral system) encoders.
- Takes CW-bit FTF codewords from the bus receiver and reconstructs the binary data word: value = sum of code[i] * FNS(i+1).
- Two-stage pipeline with valid/ready handshake and full backpressure; one codeword per cycle at full throughput.
- Sits between the bus receive register and the data sink.

Parameters:
- CW, 3, codeword width in bits (2..16).
- DW, 3, output data width; must hold FNS(CW+2)-1 (CW=3 → max value 4).
- ERRW, 8, width of the saturating error counter (used only with the optional feature).

Ports:
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high reset.
- in_code  in  CW  received FTF codeword.
- in_valid  in  1  in_code valid.
- in_ready  out  1  block can accept in_code this cycle.
- out_data  out  DW  decoded binary value.
- out_valid  out  1  out_data valid.
- out_ready  in  1  sink accepts out_data.
- out_err  out  1  codeword non-canonical (feature only; otherwise tied 0).
- err_cnt  out  ERRW  saturating count of non-canonical codewords (feature only; otherwise tied 0).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clock, reset).
- Weights: FNS(1)=1, FNS(2)=1, FNS(k)=FNS(k-1)+FNS(k-2). Bit i of the codeword carries weight FNS(i+1). For CW=3 the weights are bit0=1, bit1=1, bit2=2.
- Stage 1 (S1):
  - On accept (in_valid & in_ready), register in_code.
  - Register two partial sums: low half bits [CW/2-1:0] and high half bits [CW-1:CW/2].
  - Set s1_valid.
- Stage 2 (S2): register out_data = low + high, computed at DW bits with no truncation. Set out_valid.
- Latency: exactly 2 cycles from accept to out_valid when not stalled. Throughput is 1/cycle.
- Handshake:
  - S2 advances when !out_valid | out_ready.
  - S1 advances when S2 advances or !s1_valid.
  - in_ready = !s1_valid | S2 advances. This is combinational from out_ready; there is no skid buffer.
  - Data and flags hold stable while out_valid & !out_ready.
- Simultaneous events:
  - Accept and drain in the same cycle are allowed; there are no bubbles.
  - A full pipe with out_ready=0 drives in_ready=0, and the held codeword is not lost.
- Reset (at any time, including mid-stall):
  - out_valid=0, s1_valid=0, out_data=0, out_err=0, err_cnt=0.
  - in_ready=1 in the first cycle after reset.
  - In-flight words are discarded.
- Any CW-bit pattern decodes; the all-ones codeword gives the maximum value FNS(CW+2)-1.

Optional Feature:
- Macro: FTF_DEC_CHECK_EN.
- Defined:
  - S2 greedily re-encodes the decoded value, MSB first: bit set if remainder >= weight, then subtract.
  - It compares the result against the registered codeword. A mismatch sets out_err together with out_data.
  - err_cnt increments by 1 on each output transfer (out_valid & out_ready) with out_err=1, and saturates at all-ones.
- Undefined: no check logic; out_err=0 and err_cnt=0 constantly.

Decomposition:
- Shared package/include (alongside FNS.vh):
  - FNS weight constant function/table up to index 18.
  - Function computing the DW minimum for a given CW.
  - Greedy-encode function shared with the encoders.
- One sub-module, ftf_fns_partial_sum: parameterised weighted sum of a bit slice with a start index. Instantiated twice in S1.

Test Plan (CW=3, DW=3):
- Reset then in_code=3'b111 with in_valid, out_ready=1 → out_valid at cycle +2 with out_data=4 and out_err=0.
- Back-to-back stream 000, 001, 010, 100, 110 with out_ready=1 → out_data 0, 1, 1, 2, 3 on consecutive cycles, no bubbles, in_ready stays 1.
- Fill the pipe and hold out_ready=0 for 5 cycles → in_ready=0 after 2 accepts, out_data stable; release → both words delivered in order and none lost.
- FTF_DEC_CHECK_EN: inputs 101 and 011 → out_data 3 and 2, both with out_err=1 and err_cnt=2; input 110 → out_err=0.
- FTF_DEC_CHECK_EN with ERRW=2: 5 non-canonical words → err_cnt saturates at 3.
- Assert reset while the pipe is full and stalled → next cycle out_valid=0, in_ready=1, err_cnt=0.
